// File: rtl/vc_iter_muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// Mode and FSM state encodings.
package vc_iter_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        VC_MULDIV_MUL   = 2'b00,
        VC_MULDIV_MULHU = 2'b01,
        VC_MULDIV_DIVU  = 2'b10,
        VC_MULDIV_REMU  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/vc_iter_muldiv_unit_if.sv
// Request/response handshake bundle for the muldiv unit.
// The master issues requests; the slave is the unit.
interface vc_iter_muldiv_unit_if
    import vc_iter_muldiv_unit_pkg::*;
#(
    parameter int p_nbits = 32
);

    logic               domain;
    logic               req_val;
    logic               req_rdy;
    mode_t              req_mode;
    logic [p_nbits-1:0] req_a;
    logic [p_nbits-1:0] req_b;
    logic               resp_val;
    logic               resp_rdy;
    logic               resp_domain;
    logic [p_nbits-1:0] resp_result;

    modport master (
        output domain, req_val, req_mode, req_a, req_b, resp_rdy,
        input  req_rdy, resp_val, resp_domain, resp_result
    );

    modport slave (
        input  domain, req_val, req_mode, req_a, req_b, resp_rdy,
        output req_rdy, resp_val, resp_domain, resp_result
    );

endinterface

// File: rtl/vc_iter_muldiv_dpath.sv
// Datapath: operand, accumulator and counter registers,
// shift-add multiply / restoring divide step and result mux.
module vc_iter_muldiv_dpath
    import vc_iter_muldiv_unit_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_cnt_nbits = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic               step,
    input  mode_t              mode,
    input  logic [p_nbits-1:0] a,
    input  logic [p_nbits-1:0] b,
    output logic               last,
    output logic [p_nbits-1:0] result
);

    localparam int N = p_nbits;

    mode_t              mode_r;
    logic [N-1:0]       opnd;
    logic [2*N:0]       acc;
    logic [2*N:0]       acc_nxt;
    logic [p_cnt_nbits-1:0] cnt;
    logic [N:0]         sum;
    logic [N+1:0]       diff;

    // Divide: acc = {rem[N:0], quot[N-1:0]}; multiply: acc[2N-1:0] = product.
    always_comb begin
        sum     = {1'b0, acc[2*N-1:N]} + {1'b0, opnd};
        diff    = {acc[2*N:N], acc[N-1]} - {2'b00, opnd};
        acc_nxt = acc;
        if (mode_r[1]) begin
            if (!diff[N+1])
                acc_nxt = {diff[N:0], acc[N-2:0], 1'b1};
            else
                acc_nxt = {acc[2*N-1:N], acc[N-1], acc[N-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nxt = {1'b0, sum, acc[N-1:1]};
            else
                acc_nxt = {2'b00, acc[2*N-1:N], acc[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r <= VC_MULDIV_MUL;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (ld) begin
            mode_r <= mode;
            opnd   <= mode[1] ? b : a;
            acc    <= {{(N+1){1'b0}}, (mode[1] ? a : b)};
            cnt    <= p_cnt_nbits'(N);
        end else if (step) begin
            acc    <= acc_nxt;
            cnt    <= cnt - 1'b1;
        end
    end

    assign last = (cnt == p_cnt_nbits'(1));

    always_comb begin
        result = '0;
        unique case (mode_r)
            VC_MULDIV_MUL,
            VC_MULDIV_DIVU:  result = acc[N-1:0];
            VC_MULDIV_MULHU,
            VC_MULDIV_REMU:  result = acc[2*N-1:N];
        endcase
    end

endmodule

// File: rtl/vc_iter_muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU with fixed latency
// and per-transaction security domain.
module vc_iter_muldiv_unit
    import vc_iter_muldiv_unit_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_cnt_nbits = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_iter_muldiv_unit_if.slave  io,
    output logic                  busy
);

    state_t             state;
    logic               resp_val_r;
    logic               dom_r;
    logic               ld;
    logic               step;
    logic               last;
    logic [p_nbits-1:0] res;

    assign ld   = (state == IDLE) && io.req_val;
    assign step = (state == CALC);

    vc_iter_muldiv_dpath #(
        .p_nbits     (p_nbits),
        .p_cnt_nbits (p_cnt_nbits)
    ) dpath (
        .clk    (clk),
        .reset  (reset),
        .ld     (ld),
        .step   (step),
        .mode   (io.req_mode),
        .a      (io.req_a),
        .b      (io.req_b),
        .last   (last),
        .result (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_val_r <= 1'b0;
            dom_r      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (io.req_val) begin
                    state <= CALC;
                    dom_r <= io.domain;
                end
                CALC: if (last) begin
                    state      <= DONE;
                    resp_val_r <= 1'b1;
                end
                DONE: if (io.resp_rdy) begin
                    state      <= IDLE;
                    resp_val_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.req_rdy     = (state == IDLE);
    assign io.resp_val    = resp_val_r;
    assign io.resp_domain = dom_r;
    // Result is only exposed in DONE so nothing leaks across domains.
    assign io.resp_result = resp_val_r ? res : '0;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_vc_iter_muldiv_unit.sv
// Directed-vector bench for vc_iter_muldiv_unit.
module tb_vc_iter_muldiv_unit;
    import vc_iter_muldiv_unit_pkg::*;

    localparam int NB = 32;

    logic clk;
    logic reset;
    logic busy;

    vc_iter_muldiv_unit_if #(.p_nbits(NB)) io ();

    vc_iter_muldiv_unit #(.p_nbits(NB), .p_cnt_nbits(6)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        mode_t       mode;
        logic [31:0] a;
        logic [31:0] b;
        logic        dom;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic run(input string tag, input mode_t m,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic dom, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        chk({tag, ".rdy"}, 64'(io.req_rdy), 64'd1);
        io.req_val  = 1'b1;
        io.req_mode = m;
        io.req_a    = a;
        io.req_b    = b;
        io.domain   = dom;
        @(posedge clk);
        #1;
        io.req_val = 1'b0;
        io.domain  = ~dom;
        lat = 0;
        while (!io.resp_val && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'd32);
        chk({tag, ".res"}, 64'(io.resp_result), 64'(exp));
        chk({tag, ".dom"}, 64'(io.resp_domain), 64'(dom));
        @(posedge clk);
        #1;
        chk({tag, ".clr"}, {31'd0, io.resp_val, io.resp_result},
            64'd0);
    endtask

    initial begin
        vecs[0]  = '{VC_MULDIV_MUL,   32'd7,        32'd6,        1'b0, 32'd42};
        vecs[1]  = '{VC_MULDIV_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1};
        vecs[2]  = '{VC_MULDIV_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE};
        vecs[3]  = '{VC_MULDIV_DIVU,  32'd100,      32'd7,        1'b0, 32'd14};
        vecs[4]  = '{VC_MULDIV_REMU,  32'd100,      32'd7,        1'b1, 32'd2};
        vecs[5]  = '{VC_MULDIV_REMU,  32'd5,        32'd9,        1'b0, 32'd5};
        vecs[6]  = '{VC_MULDIV_DIVU,  32'd5,        32'd0,        1'b0, 32'hFFFFFFFF};
        vecs[7]  = '{VC_MULDIV_REMU,  32'd5,        32'd0,        1'b1, 32'd5};
        vecs[8]  = '{VC_MULDIV_MULHU, 32'h80000000, 32'd4,        1'b0, 32'd2};
        vecs[9]  = '{VC_MULDIV_DIVU,  32'hFFFFFFFF, 32'd1,        1'b1, 32'hFFFFFFFF};
        vecs[10] = '{VC_MULDIV_MUL,   32'h00010001, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF};
        vecs[11] = '{VC_MULDIV_DIVU,  32'hDEADBEEF, 32'h00010000, 1'b1, 32'h0000DEAD};

        reset       = 1'b1;
        io.req_val  = 1'b0;
        io.req_mode = VC_MULDIV_MUL;
        io.req_a    = '0;
        io.req_b    = '0;
        io.domain   = 1'b0;
        io.resp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdy",  64'(io.req_rdy),     64'd1);
        chk("rst.val",  64'(io.resp_val),    64'd0);
        chk("rst.busy", 64'(busy),           64'd0);
        chk("rst.res",  64'(io.resp_result), 64'd0);
        chk("rst.dom",  64'(io.resp_domain), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run($sformatf("v%0d", i), vecs[i].mode, vecs[i].a,
                vecs[i].b, vecs[i].dom, vecs[i].exp);

        // Backpressure with domain toggle and a request during DONE.
        @(negedge clk);
        io.resp_rdy = 1'b0;
        io.req_val  = 1'b1;
        io.req_mode = VC_MULDIV_MUL;
        io.req_a    = 32'd3;
        io.req_b    = 32'd3;
        io.domain   = 1'b1;
        @(posedge clk);
        #1;
        io.req_val = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) io.domain = 1'b0;
            if (c == 31) chk("bp.val31", 64'(io.resp_val), 64'd0);
            if (c == 31) chk("bp.res31", 64'(io.resp_result), 64'd0);
            if (c == 34) begin
                io.req_val  = 1'b1;
                io.req_mode = VC_MULDIV_DIVU;
                io.req_a    = 32'd50;
                io.req_b    = 32'd5;
            end
            if (c >= 32) begin
                chk($sformatf("bp.val%0d", c), 64'(io.resp_val), 64'd1);
                chk($sformatf("bp.res%0d", c), 64'(io.resp_result), 64'd9);
                chk($sformatf("bp.dom%0d", c), 64'(io.resp_domain), 64'd1);
                chk($sformatf("bp.rdy%0d", c), 64'(io.req_rdy), 64'd0);
                chk($sformatf("bp.bsy%0d", c), 64'(busy), 64'd1);
            end
        end
        io.req_val  = 1'b0;
        io.resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.rdy40", 64'(io.req_rdy),  64'd1);
        chk("bp.val40", 64'(io.resp_val), 64'd0);
        chk("bp.bsy40", 64'(busy),        64'd0);

        // Reset in the middle of a divide.
        @(negedge clk);
        io.req_val  = 1'b1;
        io.req_mode = VC_MULDIV_DIVU;
        io.req_a    = 32'd100;
        io.req_b    = 32'd7;
        io.domain   = 1'b1;
        @(posedge clk);
        #1;
        io.req_val = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mr.bsy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mr.rdy", 64'(io.req_rdy),     64'd1);
        chk("mr.val", 64'(io.resp_val),    64'd0);
        chk("mr.res", 64'(io.resp_result), 64'd0);
        chk("mr.dom", 64'(io.resp_domain), 64'd0);
        run("mr.mul", VC_MULDIV_MUL, 32'd3, 32'd4, 1'b0, 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vc_iter_muldiv_unit.md
Name: vc_iter_muldiv_unit

Overview:
Iterative unsigned multiply/divide unit, the sequential successor to the combinational vc arithmetic components (adder, shifters, comparators). Width is parametrised, and the operation mode is selected per request: MUL, MULHU, DIVU or REMU. Request and response use val/rdy handshakes. Security domain is carried with each transaction. Latency is fixed and independent of operand values, so the block exposes no timing channel between domains.

Parameters:
p_nbits, 32, operand and result width (>= 2)
p_cnt_nbits, 6, iteration counter width; must hold p_nbits (clog2(p_nbits)+1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
domain  input  1  {L} domain of the incoming request; sampled only on accept
req_val  input  1  {L} request valid
req_rdy  output  1  {L} unit can accept a request
req_mode  input  2  {Domain domain} 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
req_a  input  p_nbits  {Domain domain} multiplicand / dividend
req_b  input  p_nbits  {Domain domain} multiplier / divisor
resp_val  output  1  {L} response valid
resp_rdy  input  1  {L} consumer ready
resp_domain  output  1  {L} domain latched at accept
resp_result  output  p_nbits  {Domain resp_domain} result
busy  output  1  {L} state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; req_rdy=1 (combinational from IDLE); resp_val=0; busy=0; resp_result=0; resp_domain=0; counter=0.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE: req_rdy=1. On req_val&&req_rdy, latch mode, a, b and domain, clear the accumulator, load counter=p_nbits, go to CALC.
  - CALC: req_rdy=0, resp_val=0. Perform one iteration per cycle and decrement the counter. When counter==1, the final iteration completes and the FSM goes to DONE.
  - DONE: resp_val=1. On resp_rdy, go to IDLE. resp_result and resp_domain stay stable while resp_rdy=0.
- Latency: accept at edge 0 gives CALC for exactly p_nbits cycles, and resp_val is high in cycle p_nbits+1 (33 by default). This holds for every mode and every operand, including divide-by-zero.
- Throughput: no overlap. Following a DONE handshake, the next accept occurs no earlier than the next cycle, so the minimum initiation interval is p_nbits+2.
- MUL/MULHU datapath:
  - 2*p_nbits product register, shift-add, examining the multiplier LSB first.
  - MUL returns bits [p_nbits-1:0]; MULHU returns bits [2*p_nbits-1:p_nbits].
  - All arithmetic is unsigned and wraps modulo 2^(2*p_nbits).
- DIVU/REMU datapath:
  - Restoring division.
  - p_nbits+1-bit partial remainder and quotient register. Each cycle: shift {rem,quot} left by 1, trial-subtract the divisor, keep the result if it is non-negative, and set the quotient LSB accordingly.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: the iterations still run. The natural restoring result is quotient=all ones, remainder=dividend, and this is the required result (0xFFFFFFFF, a).
- Domain handling:
  - The domain input is ignored outside the IDLE accept. Changes during CALC/DONE do not affect resp_domain.
  - In IDLE and CALC, resp_result is driven 0 so no stale data from a prior domain is visible.
- Reset mid-operation: reset aborts any state. Next cycle is IDLE with resp_val=0 and resp_result=0; the in-flight transaction is discarded.
- Simultaneous req_val in DONE: ignored, because req_rdy=0.
- Undefined req_mode values are impossible (2-bit full encoding).

Decomposition:
- Shared package/include vc-muldiv-consts holds:
  - mode encodings: VC_MULDIV_MUL, VC_MULDIV_MULHU, VC_MULDIV_DIVU, VC_MULDIV_REMU
  - state encodings: IDLE, CALC, DONE
- One natural sub-module: vc_iter_muldiv_dpath, containing the operand, accumulator and counter registers, the adder/subtractor and the result mux. It takes control signals from the FSM in the top level.
- The datapath reuses vc_Adder / vc_Subtractor-style logic inline; no new arithmetic primitives are needed.

Test Plan:
- MUL a=7, b=6, domain=0 -> accept at cycle 0, resp_val first high at cycle 33, resp_result=42, resp_domain=0.
- MUL and MULHU with a=b=0xFFFFFFFF -> MUL gives 0x00000001, MULHU gives 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; REMU 5/9 -> 5.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both with resp_val at cycle 33, identical to nonzero divisors.
- Backpressure and domain: MUL 3*3 with domain=1; toggle domain to 0 at cycle 5; hold resp_rdy=0 for cycles 33-38. Required: resp_result=9 and resp_domain=1, stable throughout; req_rdy=0 and busy=1 until the handshake at cycle 39; req_rdy=1 in cycle 40.
- Reset mid-CALC: assert reset at cycle 10 of a DIVU. Required in the next cycle: req_rdy=1, resp_val=0, resp_result=0. A following MUL 3*4 returns 12 after full latency.
